// File: rtl/serial_add_sched_pkg.sv
// Shared types and defaults for the bit-serial adder built on a single half-adder cell.
package serial_add_sched_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPh0  = 2'd1,
        StPh1  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/half_add_cell.sv
// Single combinational half-adder cell; the only arithmetic element in the adder.
module half_add_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_sched.sv
// Bit-serial adder: each bit takes two phases through one shared half-adder cell
// (PH0: a^b / a&b, PH1: propagate with the running carry).
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             p_q, p_d;
    logic             g_q, g_d;
    logic             cout_q, cout_d;

    logic cell_x, cell_y, cell_s, cell_c;

    // Per-input 2:1 mux: operand bits in PH0, partial sum and carry in PH1.
    always_comb begin
        if (state_q == StPh1) begin
            cell_x = p_q;
            cell_y = carry_q;
        end else begin
            cell_x = a_q[idx_q];
            cell_y = b_q[idx_q];
        end
    end

    half_add_cell u_cell (
        .x (cell_x),
        .y (cell_y),
        .s (cell_s),
        .c (cell_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        p_d     = p_q;
        g_d     = g_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = StPh0;
                end
            end
            StPh0: begin
                p_d     = cell_s;
                g_d     = cell_c;
                state_d = StPh1;
            end
            StPh1: begin
                sum_d[idx_q] = cell_s;
                carry_d      = g_q | cell_c;
                if (idx_q != LastIdx) begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StPh0;
                end else begin
                    cout_d  = g_q | cell_c;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            p_q     <= p_d;
            g_q     <= g_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched: directed scenarios on one instance plus an
// exhaustive operand sweep spread across 64 lock-stepped instances.
module tb_serial_add_sched;

    localparam int NumSw = 64;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       sw_rst_n;
    logic       sw_start;
    logic [7:0] sw_a [NumSw];
    logic [7:0] sw_b;
    logic       sw_busy [NumSw];
    logic       sw_done [NumSw];
    logic       sw_cout [NumSw];
    logic [7:0] sw_sum [NumSw];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   sw_go = 1'b0;
    bit   sw_fin = 1'b0;
    exp_t q[$];
    logic [9:0] sw_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sched #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    for (genvar k = 0; k < NumSw; k++) begin : g_sw
        serial_add_sched #(.WIDTH(8)) u_sw (
            .clk   (clk),
            .rst_n (sw_rst_n),
            .start (sw_start),
            .a     (sw_a[k]),
            .b     (sw_b),
            .busy  (sw_busy[k]),
            .done  (sw_done[k]),
            .sum   (sw_sum[k]),
            .cout  (sw_cout[k])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drives start for one cycle (cycle 0); the expected result is due in cycle 17.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] es, input logic ec, input bit track);
        exp_t e;
        a = ia;
        b = ib;
        start = 1'b1;
        if (track) begin
            e.sum = es;
            e.cout = ec;
            e.cyc = cyc + 17;
            q.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    initial begin
        int guard;
        bit busy_ok;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sw_rst_n = 1'b0;
        sw_start = 1'b0;
        sw_b = '0;
        for (int k = 0; k < NumSw; k++) sw_a[k] = '0;

        fork
            // Monitor: pops expectations whenever a done pulse appears.
            forever begin
                @(negedge clk);
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sum", int'(sum), int'(e.sum));
                        chk("cout", int'(cout), int'(e.cout));
                        chk("done_cycle", cyc, e.cyc);
                    end
                end
                if (sw_done[0]) begin
                    if (sw_q.size() == 0) begin
                        chk("sweep_unexpected_done", 1, 0);
                    end else begin
                        logic [9:0] ent;
                        ent = sw_q.pop_front();
                        for (int k = 0; k < NumSw; k++) begin
                            logic [8:0] s9;
                            s9 = 9'(4 * k + int'(ent[9:8])) + 9'(ent[7:0]);
                            chk("sweep", int'({sw_done[k], sw_busy[k], sw_cout[k], sw_sum[k]}),
                                int'({2'b11, s9}));
                        end
                    end
                end else begin
                    for (int k = 1; k < NumSw; k++)
                        if (sw_done[k]) chk("sweep_done_skew", k, 0);
                end
            end
            // Sweep driver: instance k covers a = 4k..4k+3 against every b.
            begin
                wait (sw_go);
                for (int off = 0; off < 4; off++) begin
                    for (int bv = 0; bv < 256; bv++) begin
                        for (int k = 0; k < NumSw; k++) sw_a[k] = 8'(4 * k + off);
                        sw_b = 8'(bv);
                        sw_start = 1'b1;
                        sw_q.push_back({2'(off), 8'(bv)});
                        step();
                        sw_start = 1'b0;
                        repeat (17) step();
                    end
                end
                sw_fin = 1'b1;
            end
        join_none

        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_cout", int'(cout), 0);
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        step();
        sw_go = 1'b1;

        // 0 + 0
        issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (17) step();
        chk("t1_idle_c18", int'(busy), 0);

        // 0xFF + 0x01, busy over cycles 1..17
        issue(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        busy_ok = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (!busy) busy_ok = 1'b0;
            step();
        end
        chk("t2_busy_window", int'(busy_ok), 1);
        chk("t2_busy_c18", int'(busy), 0);

        // Operands change in cycle 3; captured copies must be used
        issue(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1);
        repeat (2) step();
        a = 8'h00;
        b = 8'h00;
        repeat (15) step();
        a = 8'h33;
        b = 8'h44;
        repeat (3) step();
        chk("t3_hold_sum", int'(sum), 8'hFF);
        chk("t3_hold_cout", int'(cout), 0);

        // start re-pulsed in cycles 5 and 17 is ignored; start in cycle 18 is taken
        issue(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        a = 8'h7F;
        b = 8'h7F;
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        start = 1'b1;
        step();
        issue(8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
        chk("t4_accept_c19", int'(busy), 1);
        repeat (17) step();

        // Reset in cycle 6 (with start high) aborts the operation
        issue(8'h0F, 8'h01, 8'h00, 1'b0, 1'b0);
        repeat (5) step();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_sum", int'(sum), 0);
        chk("t5_rst_cout", int'(cout), 0);
        chk("t5_rst_done", int'(done), 0);
        repeat (20) step();
        issue(8'h0F, 8'h01, 8'h10, 1'b0, 1'b1);
        repeat (17) step();

        // Full-width carry
        issue(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b1);
        repeat (17) step();

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("scoreboard_drained", q.size(), 0);

        guard = 0;
        while (!sw_fin && guard < 30000) begin
            step();
            guard++;
        end
        chk("sweep_finished", int'(sw_fin), 1);
        chk("sweep_queue_drained", sw_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
